// File: rtl/ad5676_spi_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ad5676_spi_rx_if
// Description : Bundle of the serial-side inputs, the read-back select and
//               the frame/register outputs of the AD5676-style SPI receiver.
//   master : drives sclk, sync_n, sdin, ldac_n, rd_ch; observes the results
//   slave  : the receiver itself
// Revision    : 1.0  initial release
// ============================================================================
interface ad5676_spi_rx_if;
  logic        sclk;
  logic        sync_n;
  logic        sdin;
  logic        ldac_n;
  logic [2:0]  rd_ch;
  logic        frame_valid;
  logic [3:0]  frame_cmd;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic        frame_err;
  logic [15:0] dac_out;
  logic        update_pulse;

  modport master (
    output sclk, sync_n, sdin, ldac_n, rd_ch,
    input  frame_valid, frame_cmd, frame_addr, frame_data, frame_err,
           dac_out, update_pulse
  );

  modport slave (
    input  sclk, sync_n, sdin, ldac_n, rd_ch,
    output frame_valid, frame_cmd, frame_addr, frame_data, frame_err,
           dac_out, update_pulse
  );
endinterface
`default_nettype wire

// File: rtl/ad5676_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : ad5676_spi_rx
// Description : Receives 24-bit AD5676 frames on an asynchronous SPI link,
//               decodes write/update commands into 8 input and 8 DAC
//               registers, and supports the LDAC broadcast update.
//   sys_clk  : system clock (rising edge)
//   sys_rst  : asynchronous active-high reset
//   bus      : ad5676_spi_rx_if.slave (serial inputs, rd_ch, frame status,
//              dac_out read-back, update_pulse)
//   SYNC_STAGES : flip-flops per input synchronizer (>= 2)
// Revision    : 1.0  initial release
// ============================================================================
module ad5676_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst,
  ad5676_spi_rx_if.slave   bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  // Input index: 0 sclk, 1 sync_n, 2 sdin, 3 ldac_n
  logic [3:0]                  w_raw;
  logic [3:0][SYNC_STAGES-1:0] r_sync;
  logic [3:0]                  w_sync;
  logic [3:0]                  r_prev;
  logic                        r_sclk_fall, r_syncn_fall, r_syncn_rise, r_ldac_fall;

  state_t       r_state, w_state_nxt;
  logic [23:0]  r_shift, w_shift_nxt;
  logic [4:0]   r_cnt, w_cnt_nxt;
  logic         w_accept, w_error;

  logic [15:0]  r_in  [8];
  logic [15:0]  r_dac [8];
  logic [15:0]  w_in_nxt  [8];
  logic [15:0]  w_dac_nxt [8];
  logic         w_upd;

  logic [3:0]   r_frame_cmd, r_frame_addr;
  logic [15:0]  r_frame_data;
  logic         r_frame_valid, r_frame_err, r_update;

  assign w_raw = {bus.ldac_n, bus.sdin, bus.sync_n, bus.sclk};

  always_comb begin
    for (int k = 0; k < 4; k++) w_sync[k] = r_sync[k][SYNC_STAGES-1];
  end

  // Synchronizers idle high so a reset never looks like a falling edge.
  // Edge pulses are registered, so every input sees identical latency and
  // simultaneous raw events stay simultaneous after synchronization.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync       <= '1;
      r_prev       <= '1;
      r_sclk_fall  <= 1'b0;
      r_syncn_fall <= 1'b0;
      r_syncn_rise <= 1'b0;
      r_ldac_fall  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++)
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_raw[k]};
      r_prev       <= w_sync;
      r_sclk_fall  <= r_prev[0] & ~w_sync[0];
      r_syncn_fall <= r_prev[1] & ~w_sync[1];
      r_syncn_rise <= ~r_prev[1] & w_sync[1];
      r_ldac_fall  <= r_prev[3] & ~w_sync[3];
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state / shift path. r_prev[2] is the sdin sample taken in the same
  // cycle that produced r_sclk_fall, so data and clock stay aligned.
  // A final sclk fall coincident with sync_n rise is shifted before the
  // count is judged.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_syncn_fall) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (r_sclk_fall) begin
          w_shift_nxt = {r_shift[22:0], r_prev[2]};
          w_cnt_nxt   = (r_cnt == 5'd31) ? 5'd31 : r_cnt + 5'd1;
        end
        if (r_syncn_rise) begin
          w_state_nxt = S_IDLE;
          if (w_cnt_nxt == 5'd24) w_accept = 1'b1;
          else                    w_error  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file update. The frame write is resolved first so that a
  // coincident LDAC copy carries the freshly written input value.
  always_comb begin
    w_in_nxt  = r_in;
    w_dac_nxt = r_dac;
    w_upd     = 1'b0;
    if (w_accept && !w_shift_nxt[19]) begin
      case (w_shift_nxt[23:20])
        4'h1: w_in_nxt[w_shift_nxt[18:16]] = w_shift_nxt[15:0];
        4'h2: begin
          w_dac_nxt[w_shift_nxt[18:16]] = r_in[w_shift_nxt[18:16]];
          w_upd = 1'b1;
        end
        4'h3: begin
          w_in_nxt[w_shift_nxt[18:16]]  = w_shift_nxt[15:0];
          w_dac_nxt[w_shift_nxt[18:16]] = w_shift_nxt[15:0];
          w_upd = 1'b1;
        end
        default: ;
      endcase
    end
    if (r_ldac_fall) begin
      for (int i = 0; i < 8; i++) w_dac_nxt[i] = w_in_nxt[i];
      w_upd = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_frame_cmd   <= '0;
      r_frame_addr  <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_update      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_in[i]  <= '0;
        r_dac[i] <= '0;
      end
    end else begin
      r_shift       <= w_shift_nxt;
      r_cnt         <= w_cnt_nxt;
      r_frame_valid <= w_accept;
      r_frame_err   <= w_error;
      r_update      <= w_upd;
      if (w_accept) begin
        r_frame_cmd  <= w_shift_nxt[23:20];
        r_frame_addr <= w_shift_nxt[19:16];
        r_frame_data <= w_shift_nxt[15:0];
      end
      r_in  <= w_in_nxt;
      r_dac <= w_dac_nxt;
    end
  end

  assign bus.frame_valid  = r_frame_valid;
  assign bus.frame_err    = r_frame_err;
  assign bus.frame_cmd    = r_frame_cmd;
  assign bus.frame_addr   = r_frame_addr;
  assign bus.frame_data   = r_frame_data;
  assign bus.update_pulse = r_update;
  assign bus.dac_out      = r_dac[bus.rd_ch];

endmodule
`default_nettype wire

// File: tb/tb_ad5676_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad5676_spi_rx
// Description : Self-checking bench for ad5676_spi_rx: directed frames plus
//               randomized frames/LDAC strobes against a register-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ad5676_spi_rx;
  localparam int H = 3;  // sclk half period in sys_clk cycles

  logic sys_clk = 1'b0;
  logic sys_rst;
  ad5676_spi_rx_if bus ();

  ad5676_spi_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_upd    = 0;

  always @(negedge sys_clk) begin
    if (bus.frame_valid)  n_valid++;
    if (bus.frame_err)    n_err++;
    if (bus.update_pulse) n_upd++;
  end

  // Reference model state
  logic [15:0] m_in  [8];
  logic [15:0] m_dac [8];
  logic [3:0]  m_cmd, m_addr;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
    m_cmd = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_cmd"},  {28'd0, bus.frame_cmd},  {28'd0, m_cmd});
    chk({tag, "_addr"}, {28'd0, bus.frame_addr}, {28'd0, m_addr});
    chk({tag, "_data"}, {16'd0, bus.frame_data}, {16'd0, m_data});
    for (int i = 0; i < 8; i++) begin
      bus.rd_ch = 3'(i);
      #1;
      chk($sformatf("%s_dac%0d", tag, i), {16'd0, bus.dac_out}, {16'd0, m_dac[i]});
    end
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.sdin = v[i];
      tick(H);
      bus.sclk = 1'b1;
      tick(H);
      bus.sclk = 1'b0;
      tick(H);
    end
  endtask

  // Sends a frame of n bits, optionally with ldac_n falling together with
  // sync_n rising, and checks latency, pulse counts and the resulting state.
  task automatic do_frame(input string tag, input logic [31:0] v, input int n, input bit ldac_same);
    int v0, e0, u0, lat, ev, ee, eu;
    logic [3:0] c;
    logic [2:0] ch;
    v0 = n_valid; e0 = n_err; u0 = n_upd;
    bus.sync_n = 1'b0;
    tick(4);
    shift_bits(v, n);
    tick(2);
    bus.sync_n = 1'b1;
    if (ldac_same) bus.ldac_n = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (lat < 0 && (bus.frame_valid || bus.frame_err)) lat = k;
    end
    bus.ldac_n = 1'b1;
    tick(6);

    ev = 0; ee = 0; eu = 0;
    if (n == 24) begin
      ev = 1;
      c  = v[23:20];
      ch = v[18:16];
      m_cmd = c; m_addr = v[19:16]; m_data = v[15:0];
      if (!v[19]) begin
        if (c == 4'h1) m_in[ch] = v[15:0];
        if (c == 4'h2) begin m_dac[ch] = m_in[ch]; eu = 1; end
        if (c == 4'h3) begin m_in[ch] = v[15:0]; m_dac[ch] = v[15:0]; eu = 1; end
      end
    end else begin
      ee = 1;
    end
    if (ldac_same) begin
      for (int i = 0; i < 8; i++) m_dac[i] = m_in[i];
      eu = 1;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_valid"}, n_valid - v0, ev);
    chk({tag, "_err"},   n_err - e0,   ee);
    chk({tag, "_upd"},   n_upd - u0,   eu);
    check_regs(tag);
  endtask

  task automatic do_ldac(input string tag);
    int u0;
    u0 = n_upd;
    bus.ldac_n = 1'b0;
    tick(8);
    bus.ldac_n = 1'b1;
    tick(8);
    for (int i = 0; i < 8; i++) m_dac[i] = m_in[i];
    chk({tag, "_upd"}, n_upd - u0, 1);
    check_regs(tag);
  endtask

  initial begin
    int v0, e0, u0, nb;
    logic [31:0] fv;
    logic [3:0] cmd, addr;
    bit ls;

    sys_rst = 1'b1;
    bus.sclk = 1'b0; bus.sync_n = 1'b1; bus.sdin = 1'b0;
    bus.ldac_n = 1'b1; bus.rd_ch = 3'd0;
    model_reset();
    tick(3);
    chk("rst_valid", {31'd0, bus.frame_valid}, 0);
    chk("rst_err",   {31'd0, bus.frame_err},   0);
    chk("rst_upd",   {31'd0, bus.update_pulse}, 0);
    check_regs("rst");
    sys_rst = 1'b0;
    tick(4);

    do_frame("f32ABCD", 32'h032ABCD, 24, 1'b0);
    do_frame("f151234", 32'h0151234, 24, 1'b0);
    do_ldac("ldac1");
    do_frame("bits23", 32'h03_1AAAA & 32'h7FFFFF, 23, 1'b0);
    do_frame("bits25", 32'h1_3_6_5555, 25, 1'b0);
    do_frame("f1000FF_ldac", 32'h01000FF, 24, 1'b1);
    do_frame("f2cmd", 32'h0250000, 24, 1'b0);

    // Reset in the middle of a frame
    v0 = n_valid; e0 = n_err; u0 = n_upd;
    bus.sync_n = 1'b0;
    tick(4);
    shift_bits(32'h0000ABC, 12);
    sys_rst = 1'b1;
    tick(2);
    bus.sync_n = 1'b1;
    bus.sclk = 1'b0;
    tick(2);
    sys_rst = 1'b0;
    tick(10);
    model_reset();
    chk("midrst_valid", n_valid - v0, 0);
    chk("midrst_err",   n_err - e0,   0);
    chk("midrst_upd",   n_upd - u0,   0);
    check_regs("midrst");
    do_frame("f37FFFF", 32'h037FFFF, 24, 1'b0);
    do_frame("f395555", 32'h0395555, 24, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_ldac("rnd_ldac");
      end else begin
        cmd = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        addr = ($urandom_range(0, 9) >= 8) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        fv = {8'd0, cmd, addr, 16'($urandom)};
        nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 32)) : 24;
        if (nb != 24) fv = $urandom;
        ls = ($urandom_range(0, 5) == 0);
        do_frame("rnd", fv, nb, ls);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
